// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: generation sequencer for the life array.
// A step request runs one full generation. The FSM scans every cell
// (nxt_bit/cnt), waits for the new-state pipe to drain, and then pulses
// gen_done. Cursor/flip editing is enabled only while the FSM is idle.
// Optional auto-run timer: define LIFE_AUTORUN_EN to enable it.
module life_gen_ctrl #(
    parameter int unsigned X          = 8,
    parameter int unsigned Y          = 8,
    parameter int unsigned LOG2X      = 3,
    parameter int unsigned LOG2Y      = 3,
    parameter int unsigned PIPE_DEPTH = 9,
    parameter int unsigned GEN_W      = 16,
    parameter int unsigned PERIOD_W   = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key_nxt,
    input  logic                   key_run,
    input  logic [PERIOD_W-1:0]    period,
    output logic                   nxt_bit,
    output logic [LOG2X+LOG2Y-1:0] cnt,
    output logic                   edit_en,
    output logic                   busy,
    output logic                   gen_done,
    output logic [GEN_W-1:0]       gen_count,
    output logic                   running
);

    localparam int unsigned CntW   = LOG2X + LOG2Y;
    localparam int unsigned DrainW = $clog2(PIPE_DEPTH + 1);
    localparam logic [CntW-1:0]   LastCell  = CntW'(X * Y - 1);
    // The scan-exit cycle plus PIPE_DEPTH drain cycles, so gen_done lands
    // X*Y+PIPE_DEPTH cycles after the first scanned cell.
    localparam logic [DrainW-1:0] LastDrain = DrainW'(PIPE_DEPTH);

    typedef enum logic [1:0] {StIdle, StScan, StFlush} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [GEN_W-1:0]  gen_count_q, gen_count_d;
    logic              key_nxt_q;
    logic              nxt_edge;
    logic              step_req;

    assign nxt_edge = key_nxt & ~key_nxt_q;

`ifdef LIFE_AUTORUN_EN
    logic                key_run_q;
    logic                running_q, running_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [PERIOD_W-1:0] period_last;
    logic                run_edge;
    logic                timer_fire;

    assign run_edge    = key_run & ~key_run_q;
    // A period of 0 behaves like 1, so the timer fires on its first cycle.
    assign period_last = (period == '0) ? '0 : period - 1'b1;
    assign timer_fire  = running_q && (state_q == StIdle) && (timer_q >= period_last);
    assign step_req    = nxt_edge | timer_fire;
    assign running     = running_q;

    // Run toggle and idle-time timer; the timer restarts on every idle entry and on stop.
    always_comb begin
        running_d = running_q ^ run_edge;
        timer_d   = timer_q + 1'b1;
        if (!running_q || run_edge || (state_q != StIdle) || timer_fire) begin
            timer_d = '0;
        end
    end

    // Auto-run registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_run_q <= 1'b0;
            running_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            key_run_q <= key_run;
            running_q <= running_d;
            timer_q   <= timer_d;
        end
    end
`else
    logic unused_autorun;

    assign unused_autorun = ^{key_run, period};
    assign step_req       = nxt_edge;
    assign running        = 1'b0;
`endif

    // Next-state logic and decoded outputs; requests outside idle are dropped.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        gen_count_d = gen_count_q;
        nxt_bit     = 1'b0;
        edit_en     = 1'b0;
        busy        = 1'b1;
        gen_done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                edit_en = 1'b1;
                busy    = 1'b0;
                if (step_req) begin
                    state_d = StScan;
                    cnt_d   = '0;
                end
            end
            StScan: begin
                nxt_bit = 1'b1;
                if (cnt_q == LastCell) begin
                    state_d = StFlush;
                    cnt_d   = '0;
                    drain_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFlush: begin
                if (drain_q == LastDrain) begin
                    gen_done    = 1'b1;
                    gen_count_d = gen_count_q + 1'b1;
                    state_d     = StIdle;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters and key edge register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            drain_q     <= '0;
            gen_count_q <= '0;
            key_nxt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            gen_count_q <= gen_count_d;
            key_nxt_q   <= key_nxt;
        end
    end

    assign cnt       = cnt_q;
    assign gen_count = gen_count_q;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl at default parameters.
// Cycle k = the clock period after the k-th rising edge following the key press.
module tb_life_gen_ctrl;

    logic        clk;
    logic        reset;
    logic        key_nxt;
    logic        key_run;
    logic [23:0] period;
    logic        nxt_bit;
    logic [5:0]  cnt;
    logic        edit_en;
    logic        busy;
    logic        gen_done;
    logic [15:0] gen_count;
    logic        running;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_gen = 16'd0;

    life_gen_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .key_nxt   (key_nxt),
        .key_run   (key_run),
        .period    (period),
        .nxt_bit   (nxt_bit),
        .cnt       (cnt),
        .edit_en   (edit_en),
        .busy      (busy),
        .gen_done  (gen_done),
        .gen_count (gen_count),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; key_nxt = 1'b0; key_run = 1'b0; period = 24'd0;
        #3;
        n_cmp++;
        if ({nxt_bit, cnt, edit_en, busy, gen_done, gen_count, running} !==
            {1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got nxt=%b cnt=%0d edit=%b busy=%b done=%b gen=%0d run=%b, want 0 0 1 0 0 0 0",
                     nxt_bit, cnt, edit_en, busy, gen_done, gen_count, running);
        end
        tick(); tick();
        reset = 1'b0;
        exp_gen = 16'd0;
        for (int k = 0; k < 200; k++) begin
            tick();
            n_cmp++;
            if ({nxt_bit, edit_en, gen_count, busy} !== {1'b0, 1'b1, 16'd0, 1'b0}) begin
                n_err++;
                $display("FAIL idle_quiet k=%0d: got nxt=%b edit=%b gen=%0d busy=%b, want 0 1 0 0",
                         k, nxt_bit, edit_en, gen_count, busy);
            end
        end
    endtask

    task automatic test_single_step();
        key_nxt = 1'b1;
        tick();
        key_nxt = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            n_cmp++;
            if (nxt_bit !== (k <= 64) || cnt !== ((k <= 64) ? 6'(k - 1) : 6'd0) ||
                gen_done !== (k == 74) || busy !== (k <= 74) || edit_en !== (k > 74) ||
                gen_count !== ((k <= 74) ? exp_gen : exp_gen + 16'd1)) begin
                n_err++;
                $display("FAIL single_step k=%0d: got nxt=%b cnt=%0d done=%b busy=%b edit=%b gen=%0d",
                         k, nxt_bit, cnt, gen_done, busy, edit_en, gen_count);
            end
            tick();
        end
        exp_gen = exp_gen + 16'd1;
    endtask

    task automatic test_held_key();
        int dones = 0;
        int scans = 0;
        key_nxt = 1'b1;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (gen_done === 1'b1) dones++;
            if (nxt_bit === 1'b1) scans++;
        end
        key_nxt = 1'b0;
        tick(); tick();
        exp_gen = exp_gen + 16'd1;
        n_cmp++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL held_key_dones: got %0d, want 1", dones);
        end
        n_cmp++;
        if (scans != 64) begin
            n_err++;
            $display("FAIL held_key_scan_cycles: got %0d, want 64", scans);
        end
        n_cmp++;
        if (gen_count !== exp_gen) begin
            n_err++;
            $display("FAIL held_key_gen_count: got %0d, want %0d", gen_count, exp_gen);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        key_nxt = 1'b1;
        tick();
        key_nxt = 1'b0;
        for (int k = 1; k <= 160; k++) begin
            key_nxt = (k == 30);
            if (gen_done === 1'b1) begin
                dones++;
                n_cmp++;
                if (k != 74) begin
                    n_err++;
                    $display("FAIL b2b_done_cycle: got %0d, want 74", k);
                end
            end
            if (k > 75) begin
                n_cmp++;
                if (nxt_bit !== 1'b0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_requeued k=%0d: got nxt=%b busy=%b, want 0 0", k, nxt_bit, busy);
                end
            end
            tick();
        end
        key_nxt = 1'b0;
        exp_gen = exp_gen + 16'd1;
        n_cmp++;
        if (dones != 1 || gen_count !== exp_gen) begin
            n_err++;
            $display("FAIL b2b_count: got dones=%0d gen=%0d, want 1 %0d", dones, gen_count, exp_gen);
        end
    endtask

    task automatic test_reset_mid_scan();
        key_nxt = 1'b1;
        tick();
        key_nxt = 1'b0;
        for (int k = 1; k < 40; k++) tick();
        n_cmp++;
        if (nxt_bit !== 1'b1 || cnt !== 6'd39) begin
            n_err++;
            $display("FAIL pre_reset k=40: got nxt=%b cnt=%0d, want 1 39", nxt_bit, cnt);
        end
        reset = 1'b1;
        #1;
        exp_gen = 16'd0;
        n_cmp++;
        if ({nxt_bit, cnt, busy, edit_en, gen_count} !== {1'b0, 6'd0, 1'b0, 1'b1, 16'd0}) begin
            n_err++;
            $display("FAIL async_reset: got nxt=%b cnt=%0d busy=%b edit=%b gen=%0d, want 0 0 0 1 0",
                     nxt_bit, cnt, busy, edit_en, gen_count);
        end
        tick();
        reset = 1'b0;
        tick();
        key_nxt = 1'b1;
        tick();
        key_nxt = 1'b0;
        for (int k = 1; k <= 75; k++) begin
            if (k <= 3) begin
                n_cmp++;
                if (nxt_bit !== 1'b1 || cnt !== 6'(k - 1)) begin
                    n_err++;
                    $display("FAIL rescan k=%0d: got nxt=%b cnt=%0d, want 1 %0d", k, nxt_bit, cnt, k - 1);
                end
            end
            tick();
        end
        exp_gen = 16'd1;
        n_cmp++;
        if (gen_count !== exp_gen || edit_en !== 1'b1) begin
            n_err++;
            $display("FAIL rescan_done: got gen=%0d edit=%b, want 1 1", gen_count, edit_en);
        end
    endtask

`ifdef LIFE_AUTORUN_EN
    task automatic test_autorun();
        int starts [$];
        int last_done = -1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        period = 24'd10;
        key_run = 1'b1;
        tick();
        key_run = 1'b0;
        for (int k = 1; k <= 500; k++) begin
            key_run = (k == 200);
            if (nxt_bit === 1'b1 && cnt === 6'd0) starts.push_back(k);
            if (gen_done === 1'b1) last_done = k;
            if (k == 5 || k == 250) begin
                n_cmp++;
                if (running !== (k == 5)) begin
                    n_err++;
                    $display("FAIL run_flag k=%0d: got %b, want %b", k, running, k == 5);
                end
            end
            tick();
        end
        key_run = 1'b0;
        n_cmp++;
        if (starts.size() != 3) begin
            n_err++;
            $display("FAIL autorun_gens: got %0d, want 3", starts.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (starts[i] != 11 + 84 * i) begin
                    n_err++;
                    $display("FAIL autorun_start%0d: got %0d, want %0d", i, starts[i], 11 + 84 * i);
                end
            end
        end
        n_cmp++;
        if (last_done != 252 || gen_count !== 16'd3) begin
            n_err++;
            $display("FAIL autorun_stop: got last_done=%0d gen=%0d, want 252 3", last_done, gen_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_step();
        test_held_key();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef LIFE_AUTORUN_EN
        test_autorun();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
